// File: rtl/riscv_pkg.sv
// RV32I opcode constants, the decoded-entry payload carried through the
// fetch-to-decode skid buffer, and the opcode classifier.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic r_type;
    logic i_type_lw;
    logic i_type_addi;
    logic i_type_jalr;
    logic s_type;
    logic sb_type;
    logic u_type_auipc;
    logic u_type_lui;
    logic uj_type;
  } type_flags_t;

  typedef struct packed {
    type_flags_t          flags;
    logic                 func_7_bit_6;
    logic [2:0]           func_3;
    logic                 illegal;
    logic [31:0]          instruction;
    logic [RV_XLEN-1:0]   pc;
  } decoded_instr_t;

  // One-hot class for a legal opcode; all zeros marks an unsupported encoding.
  function automatic type_flags_t decode_opcode(input logic [6:0] opcode);
    type_flags_t f;
    f = '0;
    case (opcode)
      OPC_R:      f.r_type       = 1'b1;
      OPC_LOAD:   f.i_type_lw    = 1'b1;
      OPC_IALU:   f.i_type_addi  = 1'b1;
      OPC_JALR:   f.i_type_jalr  = 1'b1;
      OPC_STORE:  f.s_type       = 1'b1;
      OPC_BRANCH: f.sb_type      = 1'b1;
      OPC_AUIPC:  f.u_type_auipc = 1'b1;
      OPC_LUI:    f.u_type_lui   = 1'b1;
      OPC_JAL:    f.uj_type      = 1'b1;
      default:    f              = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready skid buffer: main entry drives the outputs, skid entry
// catches the one input accepted while the output is stalled.
module decode_skid_buffer #(
  parameter type payload_t = logic [31:0]
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready is registered and equals "skid entry will be empty".
  logic     main_valid, main_valid_next;
  logic     skid_valid, skid_valid_next;
  payload_t main_data, main_data_next;
  payload_t skid_data, skid_data_next;
  logic     in_ready_q;
  logic     push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = main_valid && out_ready;

  always_comb begin
    main_valid_next = main_valid;
    skid_valid_next = skid_valid;
    main_data_next  = main_data;
    skid_data_next  = skid_data;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (pop || !main_valid) begin
      // Main slot frees up: oldest waiting entry (skid first) takes it.
      if (skid_valid) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = push;
        if (push) main_data_next = in_data;
      end
    end else if (push) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_next;
      skid_valid <= skid_valid_next;
      main_data  <= main_data_next;
      skid_data  <= skid_data_next;
      in_ready_q <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/instruction_type_decoder.sv
// Registered fetch-to-decode stage: classifies RV32I opcodes into one-hot
// flags, qualifies func fields, and counts accepted illegal encodings.
module instruction_type_decoder
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ILLEGAL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instruction,
  input  logic [XLEN-1:0]          pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     r_type,
  output logic                     i_type_lw,
  output logic                     i_type_addi,
  output logic                     i_type_jalr,
  output logic                     s_type,
  output logic                     sb_type,
  output logic                     u_type_auipc,
  output logic                     u_type_lui,
  output logic                     uj_type,
  output logic                     func_7_bit_6,
  output logic [2:0]               func_3,
  output logic [31:0]              instruction_out,
  output logic [XLEN-1:0]          pc_out,
  output logic                     illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  decoded_instr_t in_entry, out_entry;
  type_flags_t    flags;
  logic           is_shift;
  logic           accept;
  logic [ILLEGAL_CNT_W-1:0] cnt;

  always_comb begin
    flags    = decode_opcode(instruction[6:0]);
    is_shift = (instruction[14:12] == 3'b001) || (instruction[14:12] == 3'b101);
    in_entry              = '0;
    in_entry.flags        = flags;
    in_entry.illegal      = (flags == '0);
    in_entry.func_3       = in_entry.illegal ? 3'b000 : instruction[14:12];
    // Bit 30 only selects an operation for R-type and the I-ALU shifts.
    in_entry.func_7_bit_6 = (flags.r_type || (flags.i_type_addi && is_shift)) ?
                            instruction[30] : 1'b0;
    in_entry.instruction  = instruction;
    in_entry.pc           = RV_XLEN'(pc);
  end

  decode_skid_buffer #(
    .payload_t (decoded_instr_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  // Counted on acceptance so a later flush cannot hide an illegal fetch.
  assign accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept && in_entry.illegal && (cnt != '1)) begin
      cnt <= cnt + ILLEGAL_CNT_W'(1);
    end
  end

  assign illegal_count   = cnt;
  assign r_type          = out_entry.flags.r_type;
  assign i_type_lw       = out_entry.flags.i_type_lw;
  assign i_type_addi     = out_entry.flags.i_type_addi;
  assign i_type_jalr     = out_entry.flags.i_type_jalr;
  assign s_type          = out_entry.flags.s_type;
  assign sb_type         = out_entry.flags.sb_type;
  assign u_type_auipc    = out_entry.flags.u_type_auipc;
  assign u_type_lui      = out_entry.flags.u_type_lui;
  assign uj_type         = out_entry.flags.uj_type;
  assign func_7_bit_6    = out_entry.func_7_bit_6;
  assign func_3          = out_entry.func_3;
  assign illegal         = out_entry.illegal;
  assign instruction_out = out_entry.instruction;
  assign pc_out          = XLEN'(out_entry.pc);

endmodule

// File: tb/tb_instruction_type_decoder.sv
// Directed bench for instruction_type_decoder: decode table, skid ordering,
// flush, counter saturation and reset-over-flush.
module tb_instruction_type_decoder;

  localparam int CW = 3;

  logic clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instruction, instruction_out, pc, pc_out;
  logic r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type;
  logic u_type_auipc, u_type_lui, uj_type, func_7_bit_6, illegal;
  logic [2:0] func_3;
  logic [CW-1:0] illegal_count;
  logic [8:0] flags_v;

  localparam logic [8:0] F_R = 9'h100, F_LW = 9'h080, F_ADDI = 9'h040,
    F_JALR = 9'h020, F_S = 9'h010, F_SB = 9'h008, F_AUIPC = 9'h004,
    F_LUI = 9'h002, F_UJ = 9'h001, F_NONE = 9'h000;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instruction_type_decoder #(.XLEN(32), .ILLEGAL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_type(r_type), .i_type_lw(i_type_lw), .i_type_addi(i_type_addi),
    .i_type_jalr(i_type_jalr), .s_type(s_type), .sb_type(sb_type),
    .u_type_auipc(u_type_auipc), .u_type_lui(u_type_lui), .uj_type(uj_type),
    .func_7_bit_6(func_7_bit_6), .func_3(func_3),
    .instruction_out(instruction_out), .pc_out(pc_out),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  assign flags_v = {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type,
                    sb_type, u_type_auipc, u_type_lui, uj_type};

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single accepted transfer with out_ready=1; checks the registered result.
  task automatic send_check(input string tag, input logic [31:0] ins, input logic [31:0] p,
                            input logic [8:0] ef, input logic [2:0] e3,
                            input logic e7, input logic eil);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    instruction = ins;
    pc = p;
    step();
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_flags"}, flags_v, ef);
    check({tag, "_func_3"}, func_3, e3);
    check({tag, "_f7b6"}, func_7_bit_6, e7);
    check({tag, "_illegal"}, illegal, eil);
    check({tag, "_instr_out"}, instruction_out, ins);
    check({tag, "_pc_out"}, pc_out, p);
  endtask

  initial begin
    int popped;
    logic drop;
    // reset
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags_v, F_NONE);
    check("rst_illegal", illegal, 0);
    check("rst_f3", func_3, 0);
    check("rst_f7", func_7_bit_6, 0);
    check("rst_instr", instruction_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_cnt", illegal_count, 0);

    // R-type and I-ALU qualification of bit 30
    send_check("add",  32'h003100B3, 32'h1000, F_R,    3'b000, 1'b0, 1'b0);
    send_check("sub",  32'h403100B3, 32'h1004, F_R,    3'b000, 1'b1, 1'b0);
    send_check("addi", 32'hFFF00093, 32'h1008, F_ADDI, 3'b000, 1'b0, 1'b0);
    send_check("srai", 32'h40315093, 32'h100C, F_ADDI, 3'b101, 1'b1, 1'b0);

    // one of each remaining class
    send_check("lw",    32'h00012083, 32'h2000, F_LW,    3'b010, 1'b0, 1'b0);
    send_check("jalr",  32'h0000A067, 32'h2004, F_JALR,  3'b010, 1'b0, 1'b0);
    send_check("sw",    32'h00112023, 32'h2008, F_S,     3'b010, 1'b0, 1'b0);
    send_check("beq",   32'h00208463, 32'h200C, F_SB,    3'b000, 1'b0, 1'b0);
    send_check("auipc", 32'h00001097, 32'h2010, F_AUIPC, 3'b001, 1'b0, 1'b0);
    send_check("lui",   32'h000010B7, 32'h2014, F_LUI,   3'b001, 1'b0, 1'b0);
    send_check("jal",   32'h008000EF, 32'h2018, F_UJ,    3'b000, 1'b0, 1'b0);
    check("cnt_legal_only", illegal_count, 0);

    // illegal encodings
    send_check("zero", 32'h00000000, 32'h3000, F_NONE, 3'b000, 1'b0, 1'b1);
    check("cnt_1", illegal_count, 1);
    send_check("op7f", 32'h0000707F, 32'h3004, F_NONE, 3'b000, 1'b0, 1'b1);
    check("cnt_2", illegal_count, 2);
    step();
    check("drained", out_valid, 0);

    // stall: third input must wait, then all emerge in order
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00A00093; pc = 32'h4000;
    step();
    check("stall_a_out", instruction_out, 32'h00A00093);
    check("stall_a_ready", in_ready, 1);
    exp_q.push_back(32'h00A00093);
    instruction = 32'h00B00093; pc = 32'h4004;
    step();
    check("stall_b_ready", in_ready, 0);
    check("stall_b_hold", instruction_out, 32'h00A00093);
    exp_q.push_back(32'h00B00093);
    instruction = 32'h00C00093; pc = 32'h4008;
    step();
    check("stall_c_ready", in_ready, 0);
    check("stall_c_hold", instruction_out, 32'h00A00093);
    check("stall_c_valid", out_valid, 1);
    out_ready = 1'b1;
    popped = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drop = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) check("dup_entry", out_valid, 0);
        else begin
          check("order", instruction_out, exp_q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(instruction);
        drop = 1'b1;
      end
      step();
      if (drop) in_valid = 1'b0;
      if (!out_valid && !in_valid && exp_q.size() == 0) break;
    end
    check("drain_count", popped, 3);
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
    check("drain_in_valid", in_valid, 0);

    // flush with both entries full; flush-cycle input and handshake ignored
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00D00093; pc = 32'h5000;
    step();
    instruction = 32'h00E00093; pc = 32'h5004;
    step();
    check("fill_ready", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; instruction = 32'h00F00093; pc = 32'h5008;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    repeat (3) begin
      step();
      check("flush_stays_empty", out_valid, 0);
    end

    // flush with in_ready=1 and an illegal input: dropped, not counted
    flush = 1'b1; in_valid = 1'b1; instruction = 32'h00000000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_valid", out_valid, 0);
    check("flush2_cnt", illegal_count, 2);

    // saturation at 3'b111
    for (int i = 0; i < 5; i++)
      send_check("sat_up", 32'h00000000, 32'h6000, F_NONE, 3'b000, 1'b0, 1'b1);
    check("cnt_7", illegal_count, 7);
    send_check("sat_hold", 32'hFFFFFFFF, 32'h6004, F_NONE, 3'b000, 1'b0, 1'b1);
    check("cnt_sat", illegal_count, 7);

    // rst with flush mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00100093; pc = 32'h7000;
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst2_valid", out_valid, 0);
    check("rst2_ready", in_ready, 1);
    check("rst2_cnt", illegal_count, 0);
    check("rst2_instr", instruction_out, 0);
    check("rst2_pc", pc_out, 0);
    check("rst2_flags", flags_v, F_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_type_decoder.md
Name: instruction_type_decoder

Overview:
Registered fetch-to-decode stage that produces the one-hot instruction-class flags, func_3 and func_7_bit_6 consumed by control_decoder. It is the upstream (encoding) side of that interface. It accepts a raw 32-bit RV32I instruction and PC via valid/ready, classifies the opcode, flags illegal encodings, and presents a registered result through a 2-entry skid buffer, with flush support.

Parameters:
XLEN, 32, width of pc and pc_out
ILLEGAL_CNT_W, 16, width of saturating illegal-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  instruction/pc valid
in_ready  output  1  stage can accept; registered (not combinational from out_ready)
instruction  input  32  raw fetched instruction
pc  input  XLEN  address of instruction
flush  input  1  discard all buffered entries
out_valid  output  1  decoded entry valid
out_ready  input  1  downstream accepts entry
r_type  output  1  opcode 0110011
i_type_lw  output  1  opcode 0000011
i_type_addi  output  1  opcode 0010011 (all I-ALU ops)
i_type_jalr  output  1  opcode 1100111
s_type  output  1  opcode 0100011
sb_type  output  1  opcode 1100011
u_type_auipc  output  1  opcode 0010111
u_type_lui  output  1  opcode 0110111
uj_type  output  1  opcode 1101111
func_7_bit_6  output  1  instruction[30], qualified (see Behaviour)
func_3  output  3  instruction[14:12]
instruction_out  output  32  buffered raw instruction
pc_out  output  XLEN  buffered pc
illegal  output  1  entry has unsupported encoding
illegal_count  output  ILLEGAL_CNT_W  saturating count of accepted illegal entries

Behaviour:
- Reset: out_valid=0, in_ready=1, all flags/func fields/illegal=0, instruction_out=0, pc_out=0, illegal_count=0. Both buffer entries are empty.
- Accept when in_valid && in_ready. Decoded entry appears on outputs the next cycle, so latency is 1.
- Decode: exactly one type flag is 1 for a legal opcode. illegal=1 and all flags=0 when instruction[1:0]!=11 or the opcode is not in the list.
- func_7_bit_6: equals instruction[30] for r_type. For i_type_addi it equals instruction[30] only when func_3 is 001 or 101 (shifts); otherwise it is 0. It is 0 for all other classes.
- func_3: passed through for all classes and is 000 when illegal.
- Skid buffer: a main entry drives the outputs, and a skid entry holds an accepted input when out_valid && !out_ready.
  - in_ready next cycle = !skid_valid_next.
  - When the main entry drains, the skid entry moves to main in the same edge.
- Ordering: strict FIFO and no entry is ever dropped except by flush. With both entries full and out_ready=1, main is popped and skid moves into main. The concurrent input is not accepted, because in_ready was 0.
- Outputs are held stable while out_valid && !out_ready.
- Flush: takes priority over everything. Next cycle out_valid=0, skid empty, in_ready=1. Input presented in the flush cycle is dropped, and a downstream handshake in the flush cycle is ignored. illegal_count is unaffected.
- illegal_count increments by 1 per accepted entry with illegal=1 (counted on acceptance, not on output) and saturates at all-ones. It is cleared only by rst.
- rst mid-operation returns all state to reset values on the next edge, overriding flush.

Decomposition:
- Package riscv_pkg holds the opcode localparams (OPC_R, OPC_LOAD, OPC_IALU, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_AUIPC, OPC_LUI, OPC_JAL), the decoded_instr_t struct (flags, func_7_bit_6, func_3, illegal, instruction, pc) and the function decode_opcode().
- One sub-module, decode_skid_buffer, holds the generic 2-entry valid/ready skid buffer parameterised on the decoded_instr_t payload. The top contains the combinational classification and the counter.

Test Plan:
1. Accept 0x003100B3 (add) with out_ready=1. Next cycle: r_type=1, func_3=000, func_7_bit_6=0, illegal=0. Then accept 0x403100B3 (sub): func_7_bit_6=1.
2. Accept 0xFFF00093 (addi x1,x0,-1): i_type_addi=1, func_7_bit_6=0. Then 0x40315093 (srai): i_type_addi=1, func_3=101, func_7_bit_6=1.
3. Send one each of 0x00012083, 0x0000A067, 0x00112023, 0x00208463, 0x00001097, 0x000010B7, 0x008000EF. Exactly the matching flag is set for each.
4. Send 0x00000000, then 0x0000007F. Both give illegal=1 with all flags 0, and illegal_count=2.
5. Hold out_ready=0 while streaming 3 instructions: in_ready drops after 2 accepts. Release out_ready: the entries emerge in order with no loss or duplication.
6. Fill both entries, assert flush with in_valid=1. Next cycle: out_valid=0, in_ready=1, and the flush-cycle input never appears. Preset illegal_count near all-ones: it saturates at all-ones.
